// File: rtl/arp_reply_sched_if.sv
// Request/reply handshake bundle between the ARP request detector, the scheduler and the
// reply transmitter. master = detector+transmitter side, slave = scheduler.
interface arp_reply_sched_if;
  logic        req_valid;
  logic [47:0] req_mac;
  logic [31:0] req_ip;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_start;
  logic [47:0] tx_dest_mac;
  logic [31:0] tx_dest_ip;

  modport master (
    output req_valid, req_mac, req_ip, tx_ready, tx_done,
    input  tx_start, tx_dest_mac, tx_dest_ip
  );

  modport slave (
    input  req_valid, req_mac, req_ip, tx_ready, tx_done,
    output tx_start, tx_dest_mac, tx_dest_ip
  );
endinterface

// File: rtl/arp_reply_sched.sv
// Queues detected ARP requests and issues one reply at a time to the transmitter, with a
// completion timeout and a minimum idle gap between replies.
module arp_reply_sched #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned Holdoff   = 16,
  parameter int unsigned TxTimeout = 1024
) (
  input  logic             clk_i,
  input  logic             areset_i,
  input  logic             en_i,
  arp_reply_sched_if.slave bus_if,
  output logic [4:0]       pending_o,
  output logic             req_drop_o,
  output logic [7:0]       drop_cnt_o,
  output logic             err_timeout_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned TmrW = $clog2(TxTimeout + 1);
  localparam int unsigned GapW = (Holdoff > 1) ? $clog2(Holdoff) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;
  localparam logic [1:0] StAfterReply = (Holdoff == 0) ? StIdle : StGap;

  localparam logic [4:0]      DepthCnt = 5'(Depth);
  localparam logic [TmrW-1:0] TmrLast  = TmrW'(TxTimeout - 1);
  localparam logic [GapW-1:0] GapLoad  = (Holdoff == 0) ? '0 : GapW'(Holdoff - 1);

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [79:0]     mem_q [Depth];
  logic [47:0]     mac_q, mac_d;
  logic [31:0]     ip_q, ip_d;
  logic            start_q, start_d;
  logic            drop_q, drop_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            err_q, err_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic        pop, push, drop;
  logic [79:0] head;

  assign head = mem_q[rd_ptr_q];

  // The head is consumed in START; a request arriving then may take the freed slot.
  always_comb begin
    pop  = (state_q == StStart);
    push = bus_if.req_valid && ((count_q != DepthCnt) || pop);
    drop = bus_if.req_valid && (count_q == DepthCnt) && !pop;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    start_d    = 1'b0;
    drop_d     = drop;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + 5'd1;
    else if (pop && !push) count_d = count_q - 5'd1;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      StIdle: begin
        if (en_i && bus_if.tx_ready && (count_q != 5'd0)) begin
          state_d = StStart;
          mac_d   = head[79:32];
          ip_d    = head[31:0];
          start_d = 1'b1;
        end
      end
      StStart: begin
        state_d = StWait;
        tmr_d   = '0;
      end
      StWait: begin
        // Done wins over a coincident expiry.
        if (bus_if.tx_done) begin
          state_d = StAfterReply;
          gap_d   = GapLoad;
        end else if (tmr_q == TmrLast) begin
          err_d   = 1'b1;
          state_d = StAfterReply;
          gap_d   = GapLoad;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mac_q      <= '0;
      ip_q       <= '0;
      start_q    <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
      tmr_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mac_q      <= mac_d;
      ip_q       <= ip_d;
      start_q    <= start_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !areset_i) mem_q[wr_ptr_q] <= {bus_if.req_mac, bus_if.req_ip};
  end

  assign bus_if.tx_start    = start_q;
  assign bus_if.tx_dest_mac = mac_q;
  assign bus_if.tx_dest_ip  = ip_q;
  assign pending_o          = count_q;
  assign req_drop_o         = drop_q;
  assign drop_cnt_o         = drop_cnt_q;
  assign err_timeout_o      = err_q;
endmodule

// File: tb/tb_arp_reply_sched.sv
// Bench for arp_reply_sched: two instances (Holdoff 16 / timeout 64, Holdoff 0 / timeout 8)
// share one stimulus; vector table, directed corner sequences, randomized run vs. model.
module tb_arp_reply_sched;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, rv = 1'b0, rdy = 1'b0, done = 1'b0;
  logic [47:0] mac = '0;
  logic [31:0] ip = '0;

  logic [4:0] pend_a, pend_b;
  logic       drop_a, drop_b, err_a, err_b;
  logic [7:0] dcnt_a, dcnt_b;

  arp_reply_sched_if if_a ();
  arp_reply_sched_if if_b ();

  assign if_a.req_valid = rv;
  assign if_a.req_mac   = mac;
  assign if_a.req_ip    = ip;
  assign if_a.tx_ready  = rdy;
  assign if_a.tx_done   = done;
  assign if_b.req_valid = rv;
  assign if_b.req_mac   = mac;
  assign if_b.req_ip    = ip;
  assign if_b.tx_ready  = rdy;
  assign if_b.tx_done   = done;

  arp_reply_sched #(.Depth(Depth), .Holdoff(16), .TxTimeout(64)) u_dut_a (
    .clk_i        (clk),
    .areset_i     (rst),
    .en_i         (en),
    .bus_if       (if_a),
    .pending_o    (pend_a),
    .req_drop_o   (drop_a),
    .drop_cnt_o   (dcnt_a),
    .err_timeout_o(err_a)
  );

  arp_reply_sched #(.Depth(Depth), .Holdoff(0), .TxTimeout(8)) u_dut_b (
    .clk_i        (clk),
    .areset_i     (rst),
    .en_i         (en),
    .bus_if       (if_b),
    .pending_o    (pend_b),
    .req_drop_o   (drop_b),
    .drop_cnt_o   (dcnt_b),
    .err_timeout_o(err_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mac_of(input int k);
    return (k == 0) ? 48'h0 : 48'h0011_2233_4400 + 48'(k);
  endfunction

  function automatic logic [31:0] ip_of(input int k);
    return (k == 0) ? 32'h0 : 32'hC0A8_0000 + 32'(k);
  endfunction

  function automatic logic [95:0] snap(input bit use_b);
    if (use_b)
      return {if_b.tx_start, if_b.tx_dest_mac, if_b.tx_dest_ip, pend_b, drop_b, dcnt_b, err_b};
    return {if_a.tx_start, if_a.tx_dest_mac, if_a.tx_dest_ip, pend_a, drop_a, dcnt_a, err_a};
  endfunction

  task automatic wait_start(input bit use_b, input int bound, output int n);
    n = 0;
    while (!(use_b ? if_b.tx_start : if_a.tx_start) && n < bound) begin
      step();
      n++;
    end
  endtask

  // Reference model: FIFO as a queue, reply progress as absolute cycle timestamps.
  logic [79:0] mq[$];
  bit          m_busy;
  longint      cyc, m_scyc, m_idle_at;
  logic [47:0] m_mac;
  logic [31:0] m_ip;
  logic        m_drop, m_err;
  int          m_dcnt;

  task automatic model_step(input int unsigned h, input int unsigned t);
    bit is_start, is_wait, is_idle;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_idle_at = cyc + 1; m_mac = '0; m_ip = '0;
      m_drop = 0; m_dcnt = 0; m_err = 0;
      cyc++;
      return;
    end
    is_start = m_busy && (cyc == m_scyc);
    is_wait  = m_busy && (cyc > m_scyc);
    is_idle  = !m_busy && (cyc >= m_idle_at);
    if (is_idle && en && rdy && mq.size() > 0) begin
      {m_mac, m_ip} = mq[0];
      m_busy = 1;
      m_scyc = cyc + 1;
    end
    if (is_start) void'(mq.pop_front());
    m_drop = 0;
    if (rv) begin
      if (mq.size() < int'(Depth)) mq.push_back({mac, ip});
      else begin
        m_drop = 1;
        if (m_dcnt < 255) m_dcnt++;
      end
    end
    if (is_wait) begin
      if (done) begin
        m_busy = 0; m_idle_at = cyc + 1 + longint'(h);
      end else if (cyc - m_scyc == longint'(t)) begin
        m_err = 1; m_busy = 0; m_idle_at = cyc + 1 + longint'(h);
      end
    end
    cyc++;
  endtask

  task automatic run_random(input bit use_b, input int n);
    int unsigned h = use_b ? 0 : 16;
    int unsigned t = use_b ? 8 : 64;
    logic [95:0] exp;
    for (int i = 0; i < n; i++) begin
      rst  = (i == 0) || ($urandom_range(0, 499) == 0);
      en   = ($urandom_range(0, 9) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      done = ($urandom_range(0, use_b ? 11 : 15) == 0);
      rv   = ($urandom_range(0, 2) == 0);
      mac  = {16'($urandom), $urandom};
      ip   = $urandom;
      model_step(h, t);
      step();
      exp = {m_busy && (cyc == m_scyc), m_mac, m_ip, 5'(mq.size()), m_drop, 8'(m_dcnt), m_err};
      chk(use_b ? "rand_b" : "rand_a", snap(use_b), exp);
    end
  endtask

  typedef struct {
    logic rst, en, rv, rdy, done;
    int   k;
    logic [4:0] pend;
    logic start, drop;
    logic [7:0] dcnt;
    int   mk;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int   order[4];
    int   n, seen;

    // Overflow with tx_ready low, then push-at-full coincident with the START pop.
    vecs[0] = '{1, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 1, 0, 0, 2, 2, 0, 0, 0, 0};
    vecs[3] = '{0, 1, 1, 0, 0, 3, 3, 0, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 0, 0, 4, 4, 0, 0, 0, 0};
    vecs[5] = '{0, 1, 1, 0, 0, 5, 4, 0, 1, 1, 0};
    vecs[6] = '{0, 1, 1, 0, 0, 6, 4, 0, 1, 2, 0};
    vecs[7] = '{0, 1, 0, 1, 0, 0, 4, 1, 0, 2, 1};
    vecs[8] = '{0, 1, 1, 1, 0, 7, 4, 0, 0, 2, 1};
    vecs[9] = '{0, 1, 0, 1, 1, 0, 4, 0, 0, 2, 1};
    order   = '{2, 3, 4, 7};

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; rv = vecs[i].rv;
      rdy = vecs[i].rdy; done = vecs[i].done;
      mac = mac_of(vecs[i].k); ip = ip_of(vecs[i].k);
      step();
      chk($sformatf("vec%0d", i),
          {pend_a, if_a.tx_start, drop_a, dcnt_a, err_a, if_a.tx_dest_mac, if_a.tx_dest_ip},
          {vecs[i].pend, vecs[i].start, vecs[i].drop, vecs[i].dcnt, 1'b0,
           mac_of(vecs[i].mk), ip_of(vecs[i].mk)});
    end
    rv = 0; done = 0;

    foreach (order[j]) begin
      wait_start(0, 40, n);
      chk("order_start_seen", n < 40, 1);
      chk("order_mac", {if_a.tx_dest_mac, if_a.tx_dest_ip}, {mac_of(order[j]), ip_of(order[j])});
      step(); step();
      done = 1; step(); done = 0;
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      seen += int'(if_a.tx_start);
    end
    chk("no_fifth_start", seen, 0);

    // Single request: latency, pending, holdoff on A; timeout on B.
    rst = 1; step(); rst = 0; en = 1; rdy = 1;
    rv = 1; mac = 48'h0011_2233_4455; ip = 32'hC0A8_0001; step(); rv = 0;
    chk("single_pending1", pend_a, 1);
    step();
    chk("single_start", {if_a.tx_start, if_a.tx_dest_mac, if_a.tx_dest_ip},
        {1'b1, 48'h0011_2233_4455, 32'hC0A8_0001});
    chk("b_start", if_b.tx_start, 1);
    step();
    chk("single_pending0", pend_a, 0);
    for (int i = 0; i < 7; i++) step();
    chk("b_err_before_expiry", err_b, 0);
    step();
    chk("b_err_at_expiry", err_b, 1);
    rv = 1; mac = mac_of(2); ip = ip_of(2); step(); rv = 0;
    for (int i = 0; i < 10; i++) step();
    done = 1; step(); done = 0;
    wait_start(0, 40, n);
    chk("holdoff16_gap", n, 17);
    chk("holdoff16_mac", if_a.tx_dest_mac, mac_of(2));
    chk("a_no_timeout", err_a, 0);
    step(); step(); done = 1; step(); done = 0;
    chk("b_err_sticky", err_b, 1);

    // Gating on en, then Holdoff 0 spacing on B.
    rst = 1; step(); rst = 0; en = 0; rdy = 1;
    chk("b_err_cleared", err_b, 0);
    rv = 1; mac = mac_of(1); ip = ip_of(1); step();
    mac = mac_of(2); ip = ip_of(2); step(); rv = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen += int'(if_a.tx_start) + int'(if_b.tx_start);
    end
    chk("gated_no_start", seen, 0);
    chk("gated_pending", pend_a, 2);
    en = 1; step();
    chk("ungated_start_a", if_a.tx_start, 1);
    chk("ungated_start_b", if_b.tx_start, 1);
    step(); step(); done = 1; step(); done = 0;
    wait_start(1, 20, n);
    chk("holdoff0_gap", n, 1);
    chk("holdoff0_mac", if_b.tx_dest_mac, mac_of(2));

    // Reset in the middle of a reply with three entries still queued.
    rst = 1; step(); rst = 0; en = 1; rdy = 1;
    for (int k = 1; k <= 4; k++) begin
      rv = 1; mac = mac_of(k); ip = ip_of(k); step();
    end
    rv = 0; step();
    chk("midreply_pending3", pend_a, 3);
    rst = 1; step(); rst = 0;
    chk("midreply_reset_outputs", snap(0), 96'h0);
    done = 1; step(); done = 0; step(); step();
    chk("late_done_ignored", {if_a.tx_start, pend_a}, 6'h0);
    rv = 1; mac = mac_of(9); ip = ip_of(9); step(); rv = 0; step();
    chk("post_reset_start", {if_a.tx_start, if_a.tx_dest_mac}, {1'b1, mac_of(9)});

    cyc = 0;
    run_random(0, 1500);
    run_random(1, 1500);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/arp_reply_sched.md
# arp_reply_sched

Scheduler between the ARP request detector and the ARP reply transmitter. It queues each detected request (requester MAC and IP) in a small FIFO. It then issues one reply-start command at a time to the transmitter, waits for completion or a timeout, and enforces a minimum gap between successive replies. This decouples back-to-back request detection from the single, slower reply serializer.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- HOLDOFF, 16: idle cycles enforced after each reply completes, before the next start; 0 allowed.
- TX_TIMEOUT, 1024: cycles in WAIT without tx_done before abort; must be ≥ 1.

- clk  in  1  system clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- en  in  1  1 = may issue new replies; 0 = queue only
- req_valid  in  1  one-cycle pulse: request detected
- req_mac  in  48  requester MAC, valid with req_valid
- req_ip  in  32  requester IP, valid with req_valid
- tx_ready  in  1  transmitter idle and able to accept a start
- tx_done  in  1  one-cycle pulse: transmitter finished current reply
- tx_start  out  1  one-cycle pulse: begin reply
- tx_dest_mac  out  48  destination MAC for the reply
- tx_dest_ip  out  32  destination IP for the reply
- pending  out  5  queued entries, 0..DEPTH
- req_drop  out  1  one-cycle pulse: a request was discarded because the queue was full
- drop_cnt  out  8  saturating count of dropped requests
- err_timeout  out  1  sticky; set when a reply times out

## Operation
- Queue is a FIFO of DEPTH entries, each 80 bits {mac, ip}, with wrap-around read and write pointers.
- **Push:** on req_valid, if pending < DEPTH or a pop occurs in the same cycle.
- **Drop:** on req_valid when pending == DEPTH and no pop that cycle.
  - Entry discarded.
  - req_drop pulses the next cycle.
  - drop_cnt increments, saturating at 255.
- pending updates the cycle after push/pop. A simultaneous push and pop leaves it unchanged.
- State machine: IDLE, START, WAIT, GAP.
  - **IDLE:** if en && tx_ready && pending > 0, load tx_dest_mac/tx_dest_ip from the FIFO head and go to START.
  - **START:** tx_start = 1 for this single cycle; pop the head; go to WAIT. Clear the timeout counter.
  - **WAIT:**
    - On tx_done: go to GAP, or to IDLE if HOLDOFF == 0.
    - Otherwise the timeout counter increments; when it reaches TX_TIMEOUT, set err_timeout and go to GAP (IDLE if HOLDOFF == 0).
    - tx_done and expiry in the same cycle count as done; err_timeout is not set.
  - **GAP:** gap counter loaded with HOLDOFF−1 on entry; decrement each cycle; at 0 go to IDLE.
- tx_done outside WAIT is ignored.
- tx_dest_mac/tx_dest_ip are registered. They are stable from the START cycle until the next IDLE→START load.
- en deasserted during START/WAIT/GAP does not abort the current reply. It only blocks the next IDLE→START.
- err_timeout clears only on areset.
- **Reset (synchronous, any state, mid-reply included):**
  - State → IDLE; pointers and pending → 0.
  - tx_start = 0, tx_dest_mac = 0, tx_dest_ip = 0, req_drop = 0, drop_cnt = 0, err_timeout = 0; counters → 0.
  - A req_valid coincident with areset is not queued.

## Timing
- **Empty-queue latency:** req_valid at cycle N → pending = 1 at N+1 → state START, tx_start high at N+2 (given en, tx_ready).
- **Back-to-back throughput:** tx_done at cycle M → GAP at M+1 → IDLE at M+1+HOLDOFF → next tx_start at M+2+HOLDOFF.
- **HOLDOFF = 0:** tx_done at M → IDLE at M+1 → tx_start at M+2.
- **Timeout:** START at cycle S → expiry at S+TX_TIMEOUT (WAIT cycle count = TX_TIMEOUT).
- tx_ready is sampled only in IDLE. It may drop during WAIT without effect.
- All outputs are registered; no combinational input→output paths.

## Test plan
- **Single request:** reset, en=1, tx_ready=1; req_valid with mac 0x0011_2233_4455, ip 0xC0A8_0001 at N → tx_start at N+2 with those values; pending 1→0; tx_done after 20 cycles → next start not before tx_done+18 (HOLDOFF=16).
- **Overflow:** tx_ready=0; 6 req_valid pulses with DEPTH=4 → pending=4, req_drop pulses 2 times, drop_cnt=2. Set tx_ready=1 → 4 starts in push order, fifth never issued.
- **Push at full with pop:** pending=4, IDLE→START with req_valid in the START cycle → entry accepted, pending stays 4, no drop.
- **Timeout:** TX_TIMEOUT=8, never pulse tx_done → err_timeout set 8 cycles after START. Queue continues; err_timeout stays 1 until areset.
- **Reset mid-reply:** areset during WAIT with pending=3 → next cycle all outputs 0, pending=0, state IDLE. Late tx_done is ignored.
- **Gating:** en=0 with 2 queued → no tx_start. en=1 → tx_start within 1 cycle from IDLE. HOLDOFF=0 run → starts 2 cycles after each tx_done.
